// File: rtl/kf_reg_file_if.sv
// kf_reg_file_if: write, read, accumulator and bulk-clear signals of the register file
interface kf_reg_file_if #(
    parameter int W     = 24,
    parameter int ADDRW = 5,
    parameter int NRP   = 2,
    parameter int NACC  = 2
);
    logic                  clr_start;
    logic                  clr_busy;
    logic                  clr_done;
    logic                  wr_en;
    logic [ADDRW-1:0]      wr_addr;
    logic [W-1:0]          wr_data;
    logic                  wr_drop;
    logic [NRP*ADDRW-1:0]  rd_addr;
    logic [NRP*W-1:0]      rd_data;
    logic [NACC*2-1:0]     acc_op;
    logic [NACC*W-1:0]     acc_d;
    logic [NACC*W-1:0]     acc_q;
    logic [NACC-1:0]       acc_ovf;

    modport master (
        output clr_start, wr_en, wr_addr, wr_data, rd_addr, acc_op, acc_d,
        input  clr_busy, clr_done, wr_drop, rd_data, acc_q, acc_ovf
    );

    modport slave (
        input  clr_start, wr_en, wr_addr, wr_data, rd_addr, acc_op, acc_d,
        output clr_busy, clr_done, wr_drop, rd_data, acc_q, acc_ovf
    );
endinterface

// File: rtl/kf_reg_file.sv
// kf_reg_file: multi-port register bank with forwarding, saturating accumulators and bulk clear
module kf_reg_file #(
    parameter int W       = 24,
    parameter int NR      = 32,
    parameter int ADDRW   = 5,
    parameter int NRP     = 2,
    parameter int NACC    = 2,
    parameter int FORWARD = 1,
    parameter int RDLAT   = 0
) (
    input  logic          clk,
    input  logic          rst,
    kf_reg_file_if.slave  bus
);
    localparam logic [31:0] NR_U = 32'(NR);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state_q, state_d;
    logic [ADDRW-1:0]  cnt_q, cnt_d;
    logic              clr_done_q, clr_done_d;
    logic              wr_drop_q, wr_drop_d;
    logic [W-1:0]      mem_q [NR];
    logic [W-1:0]      mem_d [NR];
    logic [NACC*W-1:0] acc_val_q, acc_val_d;
    logic [NACC-1:0]   ovf_q, ovf_d;
    logic [NRP*W-1:0]  rd_d;
    logic              wr_ok;

    // A write is refused while clearing and in the cycle a clear is requested
    assign wr_ok = bus.wr_en && (32'(bus.wr_addr) < NR_U) && (state_q == IDLE) && !bus.clr_start;

    always_comb begin
        mem_d      = mem_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        clr_done_d = 1'b0;
        wr_drop_d  = bus.wr_en && !wr_ok;
        if (state_q == IDLE) begin
            state_d = bus.clr_start ? CLEAR : IDLE;
            cnt_d   = '0;
        end else begin
            mem_d[cnt_q] = '0;
            cnt_d        = cnt_q + 1'b1;
            state_d      = (32'(cnt_q) == NR_U - 1) ? IDLE : CLEAR;
            clr_done_d   = (32'(cnt_q) == NR_U - 1);
        end
        if (wr_ok)
            mem_d[bus.wr_addr] = bus.wr_data;
    end

    for (genvar p = 0; p < NRP; p++) begin : g_rd
        logic [ADDRW-1:0] ra;
        assign ra = bus.rd_addr[p*ADDRW +: ADDRW];
        assign rd_d[p*W +: W] = (32'(ra) >= NR_U) ? '0 :
                                (FORWARD != 0 && wr_ok && bus.wr_addr == ra) ? bus.wr_data :
                                mem_q[ra];
    end

    if (RDLAT == 1) begin : g_rdreg
        logic [NRP*W-1:0] rd_q;
        always_ff @(posedge clk or posedge rst)
            if (rst) rd_q <= '0;
            else     rd_q <= rd_d;
        assign bus.rd_data = rd_q;
    end else begin : g_rdcomb
        assign bus.rd_data = rd_d;
    end

    for (genvar i = 0; i < NACC; i++) begin : g_acc
        logic [1:0]          op;
        logic signed [W-1:0] a, d;
        logic signed [W:0]   sum;
        logic                sat_hi, sat_lo;
        assign op     = bus.acc_op[2*i +: 2];
        assign a      = acc_val_q[i*W +: W];
        assign d      = bus.acc_d[i*W +: W];
        assign sum    = {a[W-1], a} + {d[W-1], d};
        // Sign bits of the W+1 sum disagree exactly when the result leaves the W-bit range
        assign sat_hi = !sum[W] && sum[W-1];
        assign sat_lo = sum[W] && !sum[W-1];
        assign acc_val_d[i*W +: W] = (op == 2'b01) ? d :
                                     (op == 2'b11) ? '0 :
                                     (op == 2'b00) ? a :
                                     sat_hi ? {1'b0, {(W-1){1'b1}}} :
                                     sat_lo ? {1'b1, {(W-1){1'b0}}} : sum[W-1:0];
        assign ovf_d[i] = (op == 2'b11) ? 1'b0 :
                          (op == 2'b10 && (sat_hi || sat_lo)) ? 1'b1 : ovf_q[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            clr_done_q <= 1'b0;
            wr_drop_q  <= 1'b0;
            acc_val_q  <= '0;
            ovf_q      <= '0;
            for (int k = 0; k < NR; k++) mem_q[k] <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clr_done_q <= clr_done_d;
            wr_drop_q  <= wr_drop_d;
            acc_val_q  <= acc_val_d;
            ovf_q      <= ovf_d;
            mem_q      <= mem_d;
        end
    end

    assign bus.clr_busy = (state_q == CLEAR);
    assign bus.clr_done = clr_done_q;
    assign bus.wr_drop  = wr_drop_q;
    assign bus.acc_q    = acc_val_q;
    assign bus.acc_ovf  = ovf_q;
endmodule

// File: tb/tb_kf_reg_file.sv
// tb_kf_reg_file: scoreboard bench over three parameterisations of kf_reg_file
module tb_kf_reg_file;
    localparam int K_ARD0 = 0, K_ARD1 = 1, K_BRD0 = 2, K_CRD0 = 3, K_ACC0 = 4, K_ACC1 = 5,
                   K_OVF = 6, K_BUSY = 7, K_DONE = 8, K_DROP = 9, K_CDROP = 10;

    typedef struct {
        int          due;
        int          k;
        logic [23:0] v;
    } item_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr_start, wr_en;
    logic [4:0]  wr_addr;
    logic [23:0] wr_data;
    logic [9:0]  rd_addr;
    logic [3:0]  acc_op;
    logic [47:0] acc_d;
    int          cyc = 0;
    int          checks = 0;
    int          passed = 0;
    item_t       sb[$];
    string       names[11] = '{"a_rd0", "a_rd1", "b_rd0", "c_rd0", "acc0", "acc1", "ovf",
                               "clr_busy", "clr_done", "wr_drop", "c_wr_drop"};

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    kf_reg_file_if bus[3] ();

    for (genvar g = 0; g < 3; g++) begin : g_drv
        assign bus[g].clr_start = clr_start;
        assign bus[g].wr_en     = wr_en;
        assign bus[g].wr_addr   = wr_addr;
        assign bus[g].wr_data   = wr_data;
        assign bus[g].rd_addr   = rd_addr;
        assign bus[g].acc_op    = acc_op;
        assign bus[g].acc_d     = acc_d;
    end

    kf_reg_file #(.FORWARD(1), .RDLAT(0)) u_a (.clk(clk), .rst(rst), .bus(bus[0]));
    kf_reg_file #(.FORWARD(0), .RDLAT(0)) u_b (.clk(clk), .rst(rst), .bus(bus[1]));
    kf_reg_file #(.NR(30), .FORWARD(1), .RDLAT(1)) u_c (.clk(clk), .rst(rst), .bus(bus[2]));

    function automatic logic [23:0] peek(input int k);
        case (k)
            K_ARD0:  return bus[0].rd_data[23:0];
            K_ARD1:  return bus[0].rd_data[47:24];
            K_BRD0:  return bus[1].rd_data[23:0];
            K_CRD0:  return bus[2].rd_data[23:0];
            K_ACC0:  return bus[0].acc_q[23:0];
            K_ACC1:  return bus[0].acc_q[47:24];
            K_OVF:   return {22'd0, bus[0].acc_ovf};
            K_BUSY:  return {23'd0, bus[0].clr_busy};
            K_DONE:  return {23'd0, bus[0].clr_done};
            K_DROP:  return {23'd0, bus[0].wr_drop};
            K_CDROP: return {23'd0, bus[2].wr_drop};
            default: return 24'd0;
        endcase
    endfunction

    // Monitor: compares every queued expectation that falls due in the current cycle
    always @(negedge clk) begin
        int i;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].due == cyc) begin
                checks++;
                if (peek(sb[i].k) === sb[i].v) passed++;
                else $display("FAIL %s cyc=%0d got=%h exp=%h", names[sb[i].k], cyc, peek(sb[i].k), sb[i].v);
                sb.delete(i);
            end else i++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp(input int k, input logic [23:0] v, input int d);
        item_t it;
        it.due = cyc + d;
        it.k   = k;
        it.v   = v;
        sb.push_back(it);
    endtask

    task automatic wr(input int a, input logic [23:0] v);
        wr_en   = 1'b1;
        wr_addr = 5'(a);
        wr_data = v;
    endtask

    task automatic rd(input int a0, input int a1);
        rd_addr = {5'(a1), 5'(a0)};
    endtask

    task automatic accs(input logic [1:0] op1, input logic [23:0] d1, input logic [1:0] op0, input logic [23:0] d0);
        acc_op = {op1, op0};
        acc_d  = {d1, d0};
    endtask

    function automatic logic [23:0] fv(input int i);
        return 24'(i * 24'h010101 + 1);
    endfunction

    task automatic fill();
        for (int i = 0; i < 32; i++) begin
            wr(i, fv(i));
            tick();
        end
        wr_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clr_start = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr = '0; acc_op = '0; acc_d = '0;
        tick();
        exp(K_BUSY, 0, 0); exp(K_DONE, 0, 0); exp(K_DROP, 0, 0); exp(K_ACC0, 0, 0);
        exp(K_OVF, 0, 0); exp(K_ARD0, 0, 0); exp(K_CRD0, 0, 0);
        tick();
        rst = 1'b0;
        // write, dual read and forwarding
        wr(5, 24'h123456); rd(5, 5);
        exp(K_ARD0, 24'h123456, 0); exp(K_ARD1, 24'h123456, 0); exp(K_BRD0, 24'h000000, 0);
        exp(K_CRD0, 24'h123456, 1);
        tick();
        wr_en = 1'b0;
        exp(K_ARD0, 24'h123456, 0); exp(K_ARD1, 24'h123456, 0); exp(K_BRD0, 24'h123456, 0);
        exp(K_DROP, 0, 0);
        tick();
        wr(7, 24'hABCDEF); rd(7, 7);
        exp(K_CRD0, 24'hABCDEF, 1); exp(K_BRD0, 24'h000000, 0);
        tick();
        wr(31, 24'h111111); rd(31, 31);
        exp(K_ARD0, 24'h111111, 0); exp(K_CRD0, 0, 1); exp(K_CDROP, 1, 1); exp(K_DROP, 0, 1);
        tick();
        wr_en = 1'b0;
        exp(K_ARD1, 24'h111111, 0); exp(K_CRD0, 0, 1);
        tick();
        // accumulators
        accs(2'b10, 24'hFFFFFB, 2'b01, 24'h7FFFF0);
        exp(K_ACC0, 24'h7FFFF0, 1); exp(K_ACC1, 24'hFFFFFB, 1);
        tick();
        accs(2'b10, 24'hFFFFFB, 2'b10, 24'h000020);
        exp(K_ACC0, 24'h7FFFFF, 1); exp(K_ACC1, 24'hFFFFF6, 1); exp(K_OVF, 1, 1);
        tick();
        accs(2'b10, 24'hFFFFFB, 2'b01, 24'h000005);
        exp(K_ACC0, 24'h000005, 1); exp(K_ACC1, 24'hFFFFF1, 1); exp(K_OVF, 1, 1);
        tick();
        accs(2'b00, 24'h0, 2'b11, 24'h0);
        exp(K_ACC0, 0, 1); exp(K_ACC1, 24'hFFFFF1, 1); exp(K_OVF, 0, 1);
        tick();
        accs(2'b01, 24'h800005, 2'b00, 24'h0);
        exp(K_ACC1, 24'h800005, 1);
        tick();
        accs(2'b10, 24'hFFFFF0, 2'b00, 24'h0);
        exp(K_ACC1, 24'h800000, 1); exp(K_OVF, 2, 1); exp(K_ACC0, 0, 1);
        tick();
        accs(2'b11, 24'h0, 2'b10, 24'h000003);
        exp(K_ACC0, 24'h000003, 1); exp(K_ACC1, 0, 1); exp(K_OVF, 0, 1);
        tick();
        accs(2'b00, 24'h0, 2'b00, 24'h0);
        // fill and read back every entry on every port
        fill();
        for (int a = 0; a < 32; a++) begin
            rd(a, 31 - a);
            exp(K_ARD0, fv(a), 0); exp(K_ARD1, fv(31 - a), 0); exp(K_BRD0, fv(a), 0);
            exp(K_CRD0, a < 30 ? fv(a) : 24'h0, 1);
            tick();
        end
        // bulk clear with a refused write midway, then a back-to-back clear
        clr_start = 1'b1;
        for (int d = 0; d <= 33; d++) begin
            exp(K_BUSY, (d >= 1 && d <= 32) ? 24'd1 : 24'd0, d);
            exp(K_DONE, (d == 33) ? 24'd1 : 24'd0, d);
        end
        tick();
        clr_start = 1'b0;
        for (int d = 1; d <= 33; d++) begin
            if (d == 5) begin
                wr(2, 24'hFFFFFF); rd(2, 30);
                exp(K_ARD0, 0, 0); exp(K_ARD1, fv(30), 0); exp(K_DROP, 1, 1);
            end
            if (d == 6) wr_en = 1'b0;
            if (d < 33) tick();
        end
        clr_start = 1'b1;
        wr(9, 24'h000001);
        exp(K_DROP, 1, 1); exp(K_ACC0, 24'h000003, 0);
        for (int d = 1; d <= 33; d++) begin
            exp(K_BUSY, d <= 32 ? 24'd1 : 24'd0, d);
            exp(K_DONE, d == 33 ? 24'd1 : 24'd0, d);
        end
        tick();
        clr_start = 1'b0; wr_en = 1'b0;
        for (int a = 0; a < 32; a++) begin
            rd(a, 31 - a);
            exp(K_ARD0, 0, 0); exp(K_ARD1, 0, 0); exp(K_BRD0, 0, 0);
            tick();
        end
        tick();
        // reset in the middle of a clear
        fill();
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        for (int d = 1; d < 10; d++) tick();
        rst = 1'b1;
        exp(K_BUSY, 0, 0); exp(K_DONE, 0, 0); exp(K_ACC0, 0, 0);
        tick();
        rst = 1'b0;
        exp(K_BUSY, 0, 0); exp(K_DONE, 0, 0); exp(K_DONE, 0, 1); exp(K_DONE, 0, 2);
        for (int a = 0; a < 32; a++) begin
            rd(a, 31 - a);
            exp(K_ARD0, 0, 0); exp(K_ARD1, 0, 0); exp(K_BRD0, 0, 0); exp(K_CRD0, 0, 1);
            tick();
        end
        wr(3, 24'h0A0B0C); rd(3, 3);
        exp(K_ARD0, 24'h0A0B0C, 0); exp(K_BRD0, 0, 0); exp(K_CRD0, 24'h0A0B0C, 1);
        tick();
        wr_en = 1'b0;
        exp(K_BRD0, 24'h0A0B0C, 0); exp(K_ARD1, 24'h0A0B0C, 0); exp(K_DROP, 0, 0);
        tick(); tick(); tick();
        if (sb.size() != 0) begin
            checks++;
            $display("FAIL scoreboard_drain left=%0d need=0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
